spi_main_param: RTL and testbench

Parametrised full-duplex SPI main controller. It is the next generation of the fixed-frame `SPI_Main` that feeds `AES_Encrypt`, and adds:
- a per-transfer frame length (128-bit block and 130/258-bit mode-prefixed key frames through one instance);
- a programmable SCLK divider;
- all four CPOL/CPHA modes;
- several chip-selects, so multiple crypto cores can share one bus.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_edge_gen.sv | 38 +++
 rtl/spi_main_param.sv | 138 +++++++++++++
 tb/tb_spi_main_param.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// SPI main controller shared types: FSM state encoding, SPI mode constants
// and the frame-length validity helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // A frame must carry at least one bit and fit in the shift register.
  function automatic logic len_valid(input int unsigned n, input int unsigned max_w);
    return (n >= 1) && (n <= max_w);
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK edge timebase: pulses tick once every DIV clk cycles while enabled and
// tracks whether the next SCLK edge is the leading or trailing one.
// Latency: first tick DIV cycles after clr drops. Backpressure: none.
// Ports: clk/rst_n; en (count), clr (sync clear of count and phase),
//        phase_en (let ticks toggle phase); tick, phase (0 = next edge leading).
module spi_edge_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic phase_en,
  output logic tick,
  output logic phase
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      // Only SCLK edges flip the phase; SETUP/HOLD ticks leave it alone.
      if (tick && phase_en) phase <= ~phase;
    end
  end

endmodule

// File: rtl/spi_main_param.sv
// Full-duplex SPI main with per-transfer length, CPOL/CPHA and chip-select.
// Latency: cs_n falls 1 cycle after start, done DIV*(2*len+2) cycles later.
// Backpressure: start is ignored while busy; invalid requests pulse err.
// Ports: start/len/cpol/cpha/cs_sel/tx request (sampled when idle);
//        rx/busy/done/err status; cs_n/sclk/mosi/miso serial bus.
module spi_main_param
  import spi_pkg::*;
#(
  parameter int MAX_W  = 258,
  parameter int DIV    = 1,
  parameter int NUM_CS = 1,
  parameter int LEN_W  = $clog2(MAX_W + 1),
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [0:MAX_W-1]  tx,
  output logic [0:MAX_W-1]  rx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUM_CS-1:0] cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  state_t             state;
  logic [0:MAX_W-1]   tx_sr;
  logic [0:MAX_W-1]   rx_sr;
  logic [LEN_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]   len_q;
  logic               cpha_q;
  logic               tick;
  logic               phase;
  logic               req_ok;

  assign req_ok = len_valid(32'(len), MAX_W) && (int'(cs_sel) < NUM_CS);

  spi_edge_gen #(.DIV(DIV)) u_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .clr      (state == IDLE),
    .phase_en (state == SHIFT),
    .tick     (tick),
    .phase    (phase)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      len_q   <= '0;
      cpha_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cs_n    <= '1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (req_ok) begin
              state   <= SETUP;
              busy    <= 1'b1;
              cs_n    <= ~(NUM_CS'(1) << cs_sel);
              sclk    <= cpol;
              len_q   <= len;
              bit_cnt <= len;
              cpha_q  <= cpha;
              rx_sr   <= '0;
              // cpha=0 presents bit 0 before the first edge, so the shifter
              // already points at bit 1; cpha=1 drives bit 0 on the first edge.
              mosi    <= cpha ? 1'b0 : tx[0];
              tx_sr   <= cpha ? tx : (tx << 1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (tick) state <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk <= ~sclk;
            if (!phase) begin
              // leading edge
              if (!cpha_q) begin
                rx_sr <= {rx_sr[1:MAX_W-1], miso};
              end else begin
                mosi  <= tx_sr[0];
                tx_sr <= tx_sr << 1;
              end
            end else begin
              // trailing edge closes one bit period
              if (cpha_q) begin
                rx_sr <= {rx_sr[1:MAX_W-1], miso};
              end else if (bit_cnt != LEN_W'(1)) begin
                mosi  <= tx_sr[0];
                tx_sr <= tx_sr << 1;
              end
              bit_cnt <= bit_cnt - 1'b1;
              if (bit_cnt == LEN_W'(1)) state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cs_n  <= '1;
            mosi  <= 1'b0;
            // Received bits sit right-aligned in rx_sr; left-align them so
            // rx[0] is the first bit and the unused tail reads zero.
            rx    <= rx_sr << (LEN_W'(MAX_W) - len_q);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_main_param.sv
module tb_spi_main_param;
  import spi_pkg::*;

  localparam int MW = 258;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DIV=1, four chip-selects, loopback
  logic          start_a = 1'b0;
  logic [8:0]    len_a = '0;
  logic          cpol_a = 1'b0, cpha_a = 1'b0;
  logic [1:0]    cs_a = 2'd2;
  logic [0:MW-1] tx_a = '0;
  logic [0:MW-1] rx_a;
  logic          busy_a, done_a, err_a, sclk_a, mosi_a, miso_a;
  logic [3:0]    cs_n_a;
  assign miso_a = mosi_a;

  // Instance B: DIV=3, three chip-selects, slave model
  logic          start_b = 1'b0;
  logic [8:0]    len_b = '0;
  logic          cpol_b = 1'b0, cpha_b = 1'b0;
  logic [1:0]    cs_b = 2'd0;
  logic [0:MW-1] tx_b = '0;
  logic [0:MW-1] rx_b;
  logic          busy_b, done_b, err_b, sclk_b, mosi_b;
  logic          miso_b = 1'b0;
  logic [2:0]    cs_n_b;

  spi_main_param #(.MAX_W(MW), .DIV(1), .NUM_CS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .len(len_a), .cpol(cpol_a),
    .cpha(cpha_a), .cs_sel(cs_a), .tx(tx_a), .rx(rx_a), .busy(busy_a),
    .done(done_a), .err(err_a), .cs_n(cs_n_a), .sclk(sclk_a), .mosi(mosi_a),
    .miso(miso_a)
  );

  spi_main_param #(.MAX_W(MW), .DIV(3), .NUM_CS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b), .cpol(cpol_b),
    .cpha(cpha_b), .cs_sel(cs_b), .tx(tx_b), .rx(rx_b), .busy(busy_b),
    .done(done_b), .err(err_b), .cs_n(cs_n_b), .sclk(sclk_b), .mosi(mosi_b),
    .miso(miso_b)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [299:0] got, input logic [299:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mode-3 slave on chip-select 0 of instance B: shifts 8'h3C out on falling
  // edges, captures mosi on rising edges, logs edge spacing.
  logic       s_en = 1'b0;
  logic [7:0] s_tx = 8'h3C;
  logic [7:0] s_rx = '0;
  int         s_edges = 0, s_badgap = 0, s_nl = 0;
  time        s_last = 0;

  always @(sclk_b) begin
    if (s_en && !cs_n_b[0]) begin
      s_edges++;
      if (s_last != 0 && ($time - s_last) != 30) s_badgap++;
      s_last = $time;
      if (!sclk_b) begin
        if (s_nl < 8) miso_b = s_tx[7 - s_nl];
        s_nl++;
      end else begin
        s_rx = {s_rx[6:0], mosi_b};
      end
    end
  end

  // Caller raises start_a at a negedge. Counts posedges until done is seen,
  // optionally re-pulses start (with an invalid length) mid-transfer, and
  // flags any cycle where a non-selected cs line is low or err fires.
  task automatic run_a(input int poke_at, output int cyc, output int bad,
                       output logic [3:0] cs_first);
    logic [8:0] sv;
    sv = len_a;
    cyc = 0;
    bad = 0;
    cs_first = 4'h0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        start_a = 1'b0;
        cs_first = cs_n_a;
      end
      if (cyc == poke_at) begin
        start_a = 1'b1;
        len_a = 9'd0;
      end else if (cyc == poke_at + 1) begin
        start_a = 1'b0;
        len_a = sv;
      end
      if ((cs_n_a | 4'b0100) != 4'hF) bad++;
      if (err_a) bad++;
    end while (!done_a && cyc < 3000);
  endtask

  task automatic run_b(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) start_b = 1'b0;
    end while (!done_b && cyc < 3000);
  endtask

  task automatic try_err_a(input string tag, input logic [0:MW-1] rx_exp);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_err"}, 300'(err_a), 300'(1));
    check({tag, "_csn"}, 300'(cs_n_a), 300'(4'hF));
    check({tag, "_busy"}, 300'(busy_a), 300'(0));
    @(negedge clk);
    check({tag, "_err1cyc"}, 300'(err_a), 300'(0));
    check({tag, "_rx"}, 300'(rx_a), 300'(rx_exp));
  endtask

  initial begin
    logic [0:MW-1] tx1, exp1, tx2, exp2, tv;
    logic [3:0]    csf;
    int            cyc, bad;

    tx1  = {2'b00, 128'h000102030405060708090a0b0c0d0e0f, {128{1'b1}}};
    exp1 = {2'b00, 128'h000102030405060708090a0b0c0d0e0f, 128'b0};
    tx2  = {2'b11, 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, 128'b0};
    exp2 = tx2;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_csn", 300'(cs_n_a), 300'(4'hF));
    check("rst_sclk", 300'(sclk_a), 300'(0));
    check("rst_mosi", 300'(mosi_a), 300'(0));
    check("rst_busy", 300'(busy_a), 300'(0));
    check("rst_done", 300'(done_a), 300'(0));
    check("rst_err", 300'(err_a), 300'(0));
    check("rst_rx", 300'(rx_a), 300'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Loopback, mode 0, len 130
    {cpol_a, cpha_a} = MODE0;
    len_a = 9'd130;
    tx_a = tx1;
    start_a = 1'b1;
    run_a(0, cyc, bad, csf);
    check("lb130_cyc", 300'(cyc), 300'(263));
    check("lb130_cs", 300'(csf), 300'(4'b1011));
    check("lb130_bad", 300'(bad), 300'(0));
    check("lb130_rx", 300'(rx_a), 300'(exp1));
    check("lb130_busy", 300'(busy_a), 300'(0));
    check("lb130_sclk", 300'(sclk_a), 300'(0));

    // Rejected requests
    len_a = 9'd0;
    try_err_a("len0", exp1);
    len_a = 9'd259;
    try_err_a("len259", exp1);

    // All four modes, len 258, cs 2
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < MW; i++) tv[i] = (((i * 5) + (m * 3)) % 7) < 3;
      {cpol_a, cpha_a} = 2'(m);
      len_a = 9'd258;
      tx_a = tv;
      start_a = 1'b1;
      run_a(0, cyc, bad, csf);
      check($sformatf("mode%0d_cyc", m), 300'(cyc), 300'(519));
      check($sformatf("mode%0d_cs", m), 300'(csf), 300'(4'b1011));
      check($sformatf("mode%0d_bad", m), 300'(bad), 300'(0));
      check($sformatf("mode%0d_rx", m), 300'(rx_a), 300'(tv));
      check($sformatf("mode%0d_sclk", m), 300'(sclk_a), 300'(m >> 1));
    end

    // Start while busy is ignored; start in done cycle is accepted
    {cpol_a, cpha_a} = MODE0;
    len_a = 9'd130;
    tx_a = tx1;
    start_a = 1'b1;
    run_a(100, cyc, bad, csf);
    check("poke_cyc", 300'(cyc), 300'(263));
    check("poke_bad", 300'(bad), 300'(0));
    check("poke_rx", 300'(rx_a), 300'(exp1));
    check("b2b_csn_done", 300'(cs_n_a), 300'(4'hF));
    tx_a = tx2;
    start_a = 1'b1;
    run_a(0, cyc, bad, csf);
    check("b2b_cs_first", 300'(csf), 300'(4'b1011));
    check("b2b_cyc", 300'(cyc), 300'(263));
    check("b2b_rx", 300'(rx_a), 300'(exp2));

    // Instance B: mode 3 warm-up so sclk already idles high
    {cpol_b, cpha_b} = MODE3;
    len_b = 9'd8;
    tx_b = {8'hA5, {250{1'b1}}};
    start_b = 1'b1;
    run_b(cyc);
    check("d3_warm_cyc", 300'(cyc), 300'(55));
    check("d3_idle_before", 300'(sclk_b), 300'(1));
    s_en = 1'b1;
    start_b = 1'b1;
    run_b(cyc);
    s_en = 1'b0;
    check("d3_cyc", 300'(cyc), 300'(55));
    check("d3_slave_rx", 300'(s_rx), 300'(8'hA5));
    check("d3_rx", 300'(rx_b), 300'({8'h3C, 250'b0}));
    check("d3_edges", 300'(s_edges), 300'(16));
    check("d3_gaps", 300'(s_badgap), 300'(0));
    check("d3_idle_after", 300'(sclk_b), 300'(1));

    // Instance B: cs_sel == NUM_CS rejected
    cs_b = 2'd3;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    check("cs3_err", 300'(err_b), 300'(1));
    check("cs3_csn", 300'(cs_n_b), 300'(3'b111));
    check("cs3_busy", 300'(busy_b), 300'(0));
    @(negedge clk);
    check("cs3_err1cyc", 300'(err_b), 300'(0));
    check("cs3_rx", 300'(rx_b), 300'({8'h3C, 250'b0}));

    // Reset at SCLK edge 50 of a mode-2 len-130 transfer
    {cpol_a, cpha_a} = MODE2;
    len_a = 9'd130;
    tx_a = tx1;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (51) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 300'(busy_a), 300'(1));
    rst_n = 1'b0;
    #1;
    check("arst_csn", 300'(cs_n_a), 300'(4'hF));
    check("arst_sclk", 300'(sclk_a), 300'(0));
    check("arst_busy", 300'(busy_a), 300'(0));
    check("arst_rx", 300'(rx_a), 300'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh transfer after reset
    {cpol_a, cpha_a} = MODE0;
    start_a = 1'b1;
    run_a(0, cyc, bad, csf);
    check("post_cyc", 300'(cyc), 300'(263));
    check("post_rx", 300'(rx_a), 300'(exp1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
